// File: rtl/seq_detect_prog.sv
// ============================================================================
// Module      : seq_detect_prog
// Description : Runtime-programmable serial bit-pattern detector. Matches a
//               loaded pattern of 1..PAT_W bits on a qualified serial lane,
//               with overlapping or non-overlapping detection, and flags each
//               occurrence with a registered one-cycle pulse.
//
// Ports       : clock        in   system clock, rising edge
//               reset        in   synchronous active-high reset
//               load         in   capture pattern/pat_len/overlap, restart
//               pattern      in   [PAT_W-1:0] pattern, [len-1] received first
//               pat_len      in   [LEN_W-1:0] pattern length (clamped to PAT_W)
//               overlap      in   1 = overlapping, 0 = non-overlapping
//               din_valid    in   datain qualifier
//               datain       in   serial data bit
//               match        out  one-cycle pulse per detected occurrence
//               armed        out  fill >= active length and length != 0
//               match_count  out  [CNT_W-1:0] saturating match counter
//
// Options     : SEQDET_COUNT_EN - when defined, builds the saturating match
//               counter; otherwise match_count is tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_prog #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             din_valid,
  input  logic             datain,
  output logic             match,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] c_PAT_MAX = LEN_W'(PAT_W);

  // Only the newest PAT_W-1 history bits are kept: the oldest bit of a full
  // PAT_W history is shifted out on the next valid bit before any compare
  // could see it, since comparisons always use the post-shift history.
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_overlap;
  logic             r_match;

  logic [PAT_W-1:0] w_hist_n;
  logic [LEN_W-1:0] w_fill_n;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] w_len_clamped;
  logic             w_hit;

  assign w_hist_n      = {r_hist, datain};
  assign w_fill_n      = (r_fill == c_PAT_MAX) ? c_PAT_MAX : r_fill + 1'b1;
  // Low r_len bits set; a length of PAT_W shifts every one out, giving all ones.
  assign w_mask        = ~({PAT_W{1'b1}} << r_len);
  assign w_len_clamped = (pat_len > c_PAT_MAX) ? c_PAT_MAX : pat_len;

  assign w_hit = (r_len != '0) && (w_fill_n >= r_len) &&
                 (((w_hist_n ^ r_pattern) & w_mask) == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_match   <= 1'b0;
    end else if (load) begin
      r_pattern <= pattern;
      r_len     <= w_len_clamped;
      r_overlap <= overlap;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= 1'b0;
    end else if (din_valid) begin
      r_hist  <= w_hist_n[PAT_W-2:0];
      r_match <= w_hit;
      // Non-overlapping mode discards every bit the match consumed.
      r_fill  <= (w_hit && !r_overlap) ? '0 : w_fill_n;
    end else begin
      r_match <= 1'b0;
    end
  end

  assign match = r_match;
  assign armed = (r_len != '0) && (r_fill >= r_len);

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || load) begin
      r_cnt <= '0;
    end else if (din_valid && w_hit && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_count = r_cnt;
`else
  assign match_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
// ============================================================================
// Module      : tb_seq_detect_prog
// Description : Directed self-checking bench for seq_detect_prog
//               (PAT_W=8, CNT_W=2). Expected counter values depend on
//               whether SEQDET_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_prog;

  localparam int PAT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int CNT_W = 2;
`ifdef SEQDET_COUNT_EN
  localparam int c_CNT_EN = 1;
`else
  localparam int c_CNT_EN = 0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             din_valid;
  logic             datain;
  logic             match;
  logic             armed;
  logic [CNT_W-1:0] match_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  seq_detect_prog #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .din_valid   (din_valid),
    .datain      (datain),
    .match       (match),
    .armed       (armed),
    .match_count (match_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic ld, input logic v, input logic d);
    load      = ld;
    din_valid = v;
    datain    = d;
    @(posedge clock);
    #1;
    load      = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic do_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
    pattern = p;
    pat_len = l;
    overlap = ov;
    step(1'b1, 1'b0, 1'b0);
  endtask

  // Feed n bits MSB-first, checking match after each bit against expm
  // (MSB-first too), with 'gap' idle cycles between bits.
  task automatic feed(input string tag, input int n, input logic [15:0] bits,
                      input logic [15:0] expm, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, bits[n-1-i]);
      chk($sformatf("%s match b%0d", tag, i + 1), {31'b0, match}, {31'b0, expm[n-1-i]});
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b0, 1'b1);
        chk($sformatf("%s gap b%0d.%0d", tag, i + 1, g), {31'b0, match}, 32'd0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; din_valid = 1'b0; datain = 1'b0;
    pattern = '0; pat_len = '0; overlap = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("reset match", {31'b0, match}, 32'd0);
    chk("reset armed", {31'b0, armed}, 32'd0);
    chk("reset count", {30'b0, match_count}, 32'd0);

    // Overlapping 11101: hits after bits 5 and 9.
    do_load(8'b0001_1101, 4'd5, 1'b1);
    feed("ov1", 9, 16'b1_1101_1101, 16'b0_0001_0001, 0);
    chk("ov1 count", {30'b0, match_count}, 32'(c_CNT_EN * 2));
    chk("ov1 armed", {31'b0, armed}, 32'd1);

    // Non-overlapping: single hit, fill restarts so bit 9 does not hit.
    do_load(8'b0001_1101, 4'd5, 1'b0);
    feed("ov0", 9, 16'b1_1101_1101, 16'b0_0001_0000, 0);
    chk("ov0 count", {30'b0, match_count}, 32'(c_CNT_EN * 1));
    chk("ov0 armed", {31'b0, armed}, 32'd0);

    // 101 with idle gaps between bits.
    do_load(8'b0000_0101, 4'd3, 1'b1);
    feed("gap", 5, 16'b1_0101, 16'b0_0101, 3);
    chk("gap count", {30'b0, match_count}, 32'(c_CNT_EN * 2));

    // 11 over seven ones: six consecutive hits, counter saturates at 3.
    do_load(8'b0000_0011, 4'd2, 1'b1);
    feed("sat", 7, 16'b111_1111, 16'b011_1111, 0);
    chk("sat count", {30'b0, match_count}, 32'(c_CNT_EN * 3));

    // Load mid-sequence drops the sampled bit and restarts.
    do_load(8'b0001_1101, 4'd5, 1'b1);
    feed("reld", 4, 16'b1110, 16'b0000, 0);
    step(1'b1, 1'b1, 1'b1);
    chk("reld load match", {31'b0, match}, 32'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("reld match", {31'b0, match}, 32'd0);
    chk("reld armed", {31'b0, armed}, 32'd0);
    chk("reld count", {30'b0, match_count}, 32'd0);

    // After reset without load the detector is disabled.
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      chk($sformatf("noload match %0d", i), {31'b0, match}, 32'd0);
      chk($sformatf("noload armed %0d", i), {31'b0, armed}, 32'd0);
    end

    // Length 12 clamps to 8: armed only after eight valid bits.
    do_load(8'hA5, 4'd12, 1'b1);
    feed("clamp", 7, 16'b0, 16'b0, 0);
    chk("clamp armed 7", {31'b0, armed}, 32'd0);
    feed("clamp8", 1, 16'b0, 16'b0, 0);
    chk("clamp armed 8", {31'b0, armed}, 32'd1);

    // Reset overrides a simultaneous load; length returns to 0.
    reset = 1'b1;
    do_load(8'h03, 4'd2, 1'b1);
    reset = 1'b0;
    chk("rst>load armed", {31'b0, armed}, 32'd0);
    feed("rst>load", 4, 16'b1111, 16'b0000, 0);
    chk("rst>load armed2", {31'b0, armed}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detect_prog.md
# seq_detect_prog

Runtime-programmable serial bit-pattern detector, the parametrised successor to the fixed 11101 Moore detector. It matches any pattern of 1..PAT_W bits, selectable between overlapping and non-overlapping detection. It adds an input qualifier and an optional saturating match counter. It sits on a serial data lane and flags each pattern occurrence with a one-cycle registered pulse.

## Interface
- PAT_W, 8, maximum pattern length in bits (≥2).
- LEN_W, $clog2(PAT_W+1), width of the length field.
- CNT_W, 8, width of the match counter.

- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture pattern/pat_len/overlap; restarts detection.
- pattern  in  PAT_W  pattern bits; pattern[len-1] is the first bit received, pattern[0] is the last.
- pat_len  in  LEN_W  pattern length.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- din_valid  in  1  datain qualifier.
- datain  in  1  serial data bit.
- match  out  1  registered one-cycle pulse per detected occurrence.
- armed  out  1  fill count ≥ active length, and length ≠ 0.
- match_count  out  CNT_W  saturating number of matches since reset/load.

## Operation
- Internal registers:
  - hist[PAT_W-1:0] shift history.
  - fill (0..PAT_W): count of valid bits in history.
  - pattern_q, len_q, overlap_q.
  - match, cnt.
- Reset: all registers 0, including len_q = 0. The detector is therefore disabled until the first load.
- Length clamping on load: pat_len > PAT_W is stored as PAT_W. Length 0 disables matching; match never asserts and armed stays 0.
- Load cycle (priority over din_valid):
  - capture pattern_q, len_q, overlap_q;
  - fill ← 0, hist ← 0, match ← 0, cnt ← 0;
  - any datain sampled in that cycle is dropped.
- Shift cycle (din_valid=1, load=0):
  - hist_n = {hist[PAT_W-2:0], datain}.
  - fill_n = min(fill+1, PAT_W).
  - hit = (len_q≠0) && (fill_n ≥ len_q) && (hist_n[len_q-1:0] == pattern_q[len_q-1:0]). Compare through a low-len_q-bit mask.
  - hist ← hist_n; match ← hit.
  - fill ← (hit && !overlap_q) ? 0 : fill_n. Non-overlap discards all bits consumed by the match.
  - cnt ← hit ? sat_inc(cnt) : cnt. Saturates at 2^CNT_W−1 and never wraps.
- Idle cycle (din_valid=0, load=0): hist, fill and cnt are held; match ← 0. Gaps in din_valid do not break a partial sequence.
- armed is combinational from fill and len_q.

## Timing
- Latency: match is high in the cycle immediately after the clock edge that sampled the final pattern bit. This is a Moore-style registered output with no combinational path from datain.
- The match pulse width is exactly one cycle per hit. With overlap=1, back-to-back hits produce consecutive high cycles, e.g. pattern 11, len 2, stream 111.
- Effect of load: a load in cycle N takes effect on edge N. The first bit counted is the first din_valid bit after that edge.
- Reset mid-sequence clears everything on the next edge; reset overrides load.
- Simultaneous hit and counter saturation: match still pulses; cnt stays at its maximum.
- Minimum spacing of non-overlapping hits is len_q valid bits.

## Configuration
- SEQDET_COUNT_EN defined:
  - the cnt register and saturating incrementer are built;
  - match_count reflects cnt.
- SEQDET_COUNT_EN undefined:
  - no counter logic is built;
  - match_count is tied to 0;
  - all other behaviour is identical.

## Test plan
- Reset, then load pattern=8'b0001_1101, pat_len=5, overlap=1, then stream 1,1,1,0,1,1,1,0,1 (valid every cycle) -> match pulses after bit 5 and after bit 9; match_count=2.
- Same pattern with overlap=0 and the same stream -> single match after bit 5; fill restarts, no hit at bit 9; match_count=1.
- Pattern 101, len 3, overlap=1, stream 1,0,1,0,1 with din_valid low for 3 cycles between each bit -> matches after bits 3 and 5 only; match low during gaps.
- CNT_W=2 with SEQDET_COUNT_EN, pattern 11, len 2, overlap=1, stream of 7 ones -> 6 consecutive match cycles; match_count saturates at 3.
- Load asserted after 4 bits of 11101 (with din_valid=1 in the load cycle), then 1 -> no match; fill=1, armed=0, match_count=0.
- After reset with no load, stream 16 random bits -> match never asserts, armed=0. Then pat_len=12 with PAT_W=8 -> len_q=8, armed after 8 valid bits.
